instr_fetch_queue: RTL and testbench
====================================

# instr_fetch_queue

Instruction fetch front end that sits directly upstream of the single-cycle core's instruction port. It issues sequential word fetches to a latency-variable instruction memory over a valid/ready request channel and buffers returned instructions, each tagged with its PC, in a small FIFO. The core consumes them through a valid/ready handshake. Redirects from the core's next-PC logic (taken branches) flush the queue and discard in-flight stale responses.

## Interface
Parameters:
- DEPTH, 4: queue entries; power of two, at least 2. It also bounds outstanding requests.
- ADDR_W, 64: PC/address width.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- resetl  in  1  asynchronous, active-low reset.
- startpc  in  ADDR_W  boot PC; sampled once in BOOT.
- redirect  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  ADDR_W  new fetch PC; bits [1:0] forced to 0.
- req_valid  out  1  memory request valid.
- req_ready  in  1  memory accepts request.
- req_addr  out  ADDR_W  request word address.
- resp_valid  in  1  in-order response, one per accepted request, at least 1 cycle after accept, no backpressure.
- resp_data  in  32  instruction word.
- out_valid  out  1  head entry valid to core.
- out_ready  in  1  core consumes head.
- out_instr  out  32  head instruction; 0 when out_valid=0.
- out_pc  out  ADDR_W  head PC; 0 when out_valid=0.

## Operation
- States: BOOT, RUN. Reset → BOOT. In BOOT: fetch_pc←startpc, resp_pc←startpc, go to RUN. BOOT lasts exactly one cycle.
- Counters:
  - count: FIFO occupancy, 0..DEPTH.
  - inflight: accepted requests not yet answered.
  - discard: stale responses still to drop, ≤ inflight.
  - live = inflight − discard.
- Issue: in RUN, when no redirect and count+live < DEPTH, assert req_valid with req_addr=fetch_pc.
  - Once asserted, req_valid and req_addr hold until req_ready.
  - A live accept does fetch_pc += 4.
- Response: with resp_valid, if discard>0, drop it and decrement discard. Otherwise write {resp_pc, resp_data} to the FIFO and do resp_pc += 4.
- Dequeue: on out_valid && out_ready, pop the head. Simultaneous push and pop leaves count unchanged.
- Redirect at cycle t:
  - Flush the FIFO (count←0).
  - discard ← inflight + accept_t − resp_t.
  - Any response in cycle t is dropped.
  - fetch_pc, resp_pc ← redirect_pc.
  - A core pop in cycle t still completes.
  - An unaccepted pending request is kept and marked stale. When it is accepted, it increments inflight and discard but not fetch_pc. The new-stream request issues the cycle after.
- Redirect in BOOT is ignored.
- Address arithmetic wraps modulo 2^ADDR_W.
- Full: no issue while count+live = DEPTH, so a response always has a free slot.
- Reset mid-operation: all state is cleared asynchronously and in-flight responses are forgotten. The memory must also be reset.

## Timing
- Reset values: req_valid=0, req_addr=0, out_valid=0, out_instr=0, out_pc=0, state=BOOT, all counters 0.
- First req_valid: second posedge after resetl rises (BOOT, then RUN issue).
- Response to out_valid: out_valid rises the cycle after the live resp_valid; there is no bypass.
- Redirect (no pending request) at t: req_valid with redirect_pc at t+1; out_valid=0 at t+1.
- Redirect with a stale pending request: new request the cycle after the stale one is accepted.
- Throughput: one instruction/cycle sustained when the memory returns one response/cycle and DEPTH ≥ memory latency+1.

## Structure
- Package ifq_pkg: state enum (BOOT, RUN), entry struct {pc, instr}, constant INSTR_BYTES=4.
- Sub-module fetch_fifo: synchronous DEPTH-entry FIFO with push, pop, flush, count, head output. Pointers are log2(DEPTH) bits, wrapping naturally.
- Issue/discard control and PC registers are in instr_fetch_queue.

## Test plan
- Boot: startpc=0x1000, memory latency 1, out_ready=1 → req_addr 0x1000, 0x1004, …; out_pc sequence 0x1000, 0x1004, 0x1008 with matching instr words.
- Backpressure: out_ready=0, DEPTH=4 → exactly 4 requests accepted, then req_valid=0. count=4, no data lost after out_ready=1.
- Redirect with 2 in flight: latency 3, redirect_pc=0x2000 → next 2 responses dropped, first out_pc=0x2000, discard back to 0.
- Stale pending: req_ready=0 during redirect → old req_addr held until accepted, its response dropped, next req_addr=0x2000.
- Simultaneous events: redirect in the same cycle as resp_valid and an out pop → pop completes, response dropped, FIFO empty next cycle.
- Reset mid-stream: resetl low with 3 in flight → all outputs 0 immediately; restart from startpc.

Source files
------------

// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction fetch queue.
package ifq_pkg;

    // Bytes per instruction word; sequential fetch stride.
    localparam int unsigned INSTR_BYTES = 4;

    // Widest supported PC; queue entries store the PC at this width.
    localparam int unsigned MAX_ADDR_W = 64;

    typedef enum logic [0:0] {
        StBoot,
        StRun
    } ifq_state_e;

    typedef struct packed {
        logic [MAX_ADDR_W-1:0] pc;
        logic [31:0]           instr;
    } ifq_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, instr} entries with a single-cycle flush.
module fetch_fifo
    import ifq_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  ifq_entry_t       push_entry_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [CNT_W-1:0] count_o,
    output ifq_entry_t       head_o
);

    ifq_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Qualify push/pop against occupancy; a push into a full FIFO is allowed
    // only when the head leaves in the same cycle.
    always_comb begin
        do_pop  = pop_i && (count_q != '0);
        do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);
    end

    // Pointer and occupancy next state; flush empties the FIFO outright.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= push_entry_i;
        end
    end

    // Head entry and occupancy outputs.
    always_comb begin
        head_o  = mem_q[rd_ptr_q];
        count_o = count_q;
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: issues sequential word fetches, buffers
// PC-tagged responses for the core and handles redirect flushes.
module instr_fetch_queue
    import ifq_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 64
) (
    input  logic              CLK,
    input  logic              resetl,
    input  logic [ADDR_W-1:0] startpc,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [ADDR_W-1:0] req_addr,
    input  logic              resp_valid,
    input  logic [31:0]       resp_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_pc
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    // Outstanding counters also hold stale requests left behind by
    // back-to-back redirects, so they get headroom beyond DEPTH.
    localparam int unsigned OUT_W = $clog2(DEPTH) + 4;

    ifq_state_e        state_q, state_d;
    logic              run;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
    logic [OUT_W-1:0]  inflight_q, inflight_d;
    logic [OUT_W-1:0]  discard_q, discard_d;
    logic              pend_q, pend_d;
    logic              pend_stale_q, pend_stale_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;

    logic [CNT_W-1:0]  fifo_count;
    ifq_entry_t        head;
    ifq_entry_t        push_entry;

    logic              redir;
    logic [ADDR_W-1:0] redirect_pc_al;
    logic [OUT_W-1:0]  live;
    logic [OUT_W-1:0]  occupancy;
    logic              has_room;
    logic              issue_new;
    logic              accept;
    logic              accept_stale;
    logic              accept_live;
    logic              resp_drop;
    logic              push;
    logic              pop;

    // FSM state register.
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state_q <= StBoot;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: boot lasts a single cycle, then fetch runs forever.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StBoot:  state_d = StRun;
            StRun:   state_d = StRun;
            default: state_d = StBoot;
        endcase
    end

    // FSM outputs.
    always_comb begin
        run = (state_q == StRun);
    end

    // Issue, response and dequeue decisions for the current cycle.
    always_comb begin
        redir          = redirect && run;
        redirect_pc_al = {redirect_pc[ADDR_W-1:2], 2'b00};
        live           = inflight_q - discard_q;
        occupancy      = OUT_W'(fifo_count) + live;
        // Reserving a slot per live request guarantees every response fits.
        has_room       = occupancy < OUT_W'(DEPTH);
        issue_new      = run && !redir && !pend_q && has_room;

        req_valid = pend_q || issue_new;
        if (pend_q) begin
            req_addr = pend_addr_q;
        end else if (issue_new) begin
            req_addr = fetch_pc_q;
        end else begin
            req_addr = '0;
        end

        accept       = req_valid && req_ready;
        accept_stale = accept && pend_q && pend_stale_q;
        accept_live  = accept && !accept_stale;

        resp_drop = resp_valid && (redir || (discard_q != '0));
        push      = resp_valid && !resp_drop;

        push_entry.pc    = MAX_ADDR_W'(resp_pc_q);
        push_entry.instr = resp_data;

        out_valid = (fifo_count != '0);
        pop       = out_valid && out_ready;
        out_instr = out_valid ? head.instr : 32'h0;
        out_pc    = out_valid ? head.pc[ADDR_W-1:0] : '0;
    end

    // Next state of PCs, outstanding counters and the held request.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        if (!run) begin
            fetch_pc_d = startpc;
            resp_pc_d  = startpc;
        end else if (redir) begin
            fetch_pc_d = redirect_pc_al;
            resp_pc_d  = redirect_pc_al;
        end else begin
            if (accept_live) begin
                fetch_pc_d = fetch_pc_q + ADDR_W'(INSTR_BYTES);
            end
            if (push) begin
                resp_pc_d = resp_pc_q + ADDR_W'(INSTR_BYTES);
            end
        end

        inflight_d = inflight_q + OUT_W'(accept) - OUT_W'(resp_valid);

        // On redirect every request still owed a response becomes stale,
        // including one accepted this cycle.
        if (redir) begin
            discard_d = inflight_d;
        end else begin
            discard_d = discard_q + OUT_W'(accept_stale)
                      - OUT_W'(resp_valid && (discard_q != '0));
        end

        // A presented but unaccepted request must be held stable.
        pend_d       = req_valid && !req_ready;
        pend_addr_d  = req_addr;
        pend_stale_d = pend_d && (redir || (pend_q && pend_stale_q));
    end

    // Datapath registers.
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            fetch_pc_q   <= '0;
            resp_pc_q    <= '0;
            inflight_q   <= '0;
            discard_q    <= '0;
            pend_q       <= 1'b0;
            pend_stale_q <= 1'b0;
            pend_addr_q  <= '0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            resp_pc_q    <= resp_pc_d;
            inflight_q   <= inflight_d;
            discard_q    <= discard_d;
            pend_q       <= pend_d;
            pend_stale_q <= pend_stale_d;
            pend_addr_q  <= pend_addr_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i        (CLK),
        .rst_ni       (resetl),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .flush_i      (redir),
        .count_o      (fifo_count),
        .head_o       (head)
    );

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with a fixed-latency in-order memory.
module tb_instr_fetch_queue;

    typedef struct {
        logic [63:0] addr;
        int          due;
    } mreq_t;

    logic        CLK = 1'b0;
    logic        resetl;
    logic [63:0] startpc;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        resp_valid = 1'b0;
    logic [31:0] resp_data = 32'h0;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int lat = 1;

    mreq_t       mq [$];
    logic [63:0] acc_log [$];
    int          acc_cyc [$];
    logic [63:0] cons_pc [$];
    logic [31:0] cons_instr [$];
    int          cons_cyc [$];

    instr_fetch_queue #(
        .DEPTH  (4),
        .ADDR_W (64)
    ) dut (
        .CLK         (CLK),
        .resetl      (resetl),
        .startpc     (startpc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return 32'hA500_0000 ^ a[31:0];
    endfunction

    // Memory model and transaction logger: drive response mid-cycle, sample
    // handshakes just before the rising edge.
    always begin
        @(negedge CLK);
        if (resetl && mq.size() > 0 && mq[0].due <= cyc) begin
            resp_valid = 1'b1;
            resp_data  = instr_of(mq[0].addr);
        end else begin
            resp_valid = 1'b0;
            resp_data  = 32'h0;
        end
        #4;
        if (!resetl) begin
            mq.delete();
        end else begin
            if (resp_valid) void'(mq.pop_front());
            if (req_valid && req_ready) begin
                mq.push_back('{req_addr, cyc + lat});
                acc_log.push_back(req_addr);
                acc_cyc.push_back(cyc);
            end
            if (out_valid && out_ready) begin
                cons_pc.push_back(out_pc);
                cons_instr.push_back(out_instr);
                cons_cyc.push_back(cyc);
            end
        end
        cyc++;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    // Hold reset for two cycles, clear logs, release on a falling edge.
    task automatic do_reset(input logic [63:0] spc, input int latency);
        tick();
        resetl      = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        req_ready   = 1'b1;
        out_ready   = 1'b1;
        startpc     = spc;
        lat         = latency;
        repeat (2) tick();
        acc_log.delete();
        acc_cyc.delete();
        cons_pc.delete();
        cons_instr.delete();
        cons_cyc.delete();
        resetl = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        resetl      = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        req_ready   = 1'b1;
        out_ready   = 1'b1;
        startpc     = '0;

        // Reset values
        #1;
        check_eq("rst_req_valid", req_valid, 0);
        check_eq("rst_req_addr", req_addr, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_instr", out_instr, 0);
        check_eq("rst_out_pc", out_pc, 0);

        // Boot and sequential streaming, latency 1
        do_reset(64'h1000, 1);
        #1;
        check_eq("boot_no_req", req_valid, 0);
        tick();
        #1;
        check_eq("boot_req_valid", req_valid, 1);
        check_eq("boot_req_addr", req_addr, 64'h1000);
        repeat (12) tick();
        check_eq("boot_acc1", acc_log[1], 64'h1004);
        check_eq("boot_acc2", acc_log[2], 64'h1008);
        check_eq("boot_pc0", cons_pc[0], 64'h1000);
        check_eq("boot_pc1", cons_pc[1], 64'h1004);
        check_eq("boot_pc2", cons_pc[2], 64'h1008);
        check_eq("boot_instr0", cons_instr[0], 32'hA500_1000);
        check_eq("boot_instr2", cons_instr[2], 32'hA500_1008);
        check_eq("boot_latency", cons_cyc[0] - acc_cyc[0], 2);
        check_eq("boot_thruput", cons_cyc[5] - cons_cyc[0], 5);

        // Backpressure from the core fills the queue
        do_reset(64'h1000, 1);
        out_ready = 1'b0;
        repeat (15) tick();
        #1;
        check_eq("bp_accepts", acc_log.size(), 4);
        check_eq("bp_req_idle", req_valid, 0);
        check_eq("bp_out_valid", out_valid, 1);
        check_eq("bp_count", dut.fifo_count, 4);
        check_eq("bp_head_pc", out_pc, 64'h1000);
        out_ready = 1'b1;
        repeat (10) tick();
        check_eq("bp_pc0", cons_pc[0], 64'h1000);
        check_eq("bp_pc3", cons_pc[3], 64'h100C);
        check_eq("bp_instr3", cons_instr[3], 32'hA500_100C);
        check_eq("bp_pc4", cons_pc[4], 64'h1010);

        // Redirect with two requests in flight, latency 3
        do_reset(64'h1000, 3);
        repeat (3) tick();
        redirect    = 1'b1;
        redirect_pc = 64'h2000;
        #1;
        check_eq("rd_inflight", dut.inflight_q, 2);
        check_eq("rd_req_blocked", req_valid, 0);
        tick();
        redirect = 1'b0;
        #1;
        check_eq("rd_req_valid", req_valid, 1);
        check_eq("rd_req_addr", req_addr, 64'h2000);
        check_eq("rd_out_empty", out_valid, 0);
        repeat (10) tick();
        check_eq("rd_acc2", acc_log[2], 64'h2000);
        check_eq("rd_pc0", cons_pc[0], 64'h2000);
        check_eq("rd_instr0", cons_instr[0], 32'hA500_2000);
        check_eq("rd_pc1", cons_pc[1], 64'h2004);
        check_eq("rd_discard", dut.discard_q, 0);

        // Redirect while a request is held by req_ready=0
        do_reset(64'h1000, 2);
        repeat (2) tick();
        req_ready = 1'b0;
        #1;
        check_eq("st_pend_addr", req_addr, 64'h1004);
        tick();
        redirect    = 1'b1;
        redirect_pc = 64'h2000;
        tick();
        redirect = 1'b0;
        #1;
        check_eq("st_hold_valid", req_valid, 1);
        check_eq("st_hold_addr", req_addr, 64'h1004);
        tick();
        req_ready = 1'b1;
        tick();
        #1;
        check_eq("st_new_valid", req_valid, 1);
        check_eq("st_new_addr", req_addr, 64'h2000);
        repeat (10) tick();
        check_eq("st_acc1", acc_log[1], 64'h1004);
        check_eq("st_acc2", acc_log[2], 64'h2000);
        check_eq("st_pc0", cons_pc[0], 64'h2000);
        check_eq("st_discard", dut.discard_q, 0);

        // Redirect coinciding with a response and a core pop
        do_reset(64'h1000, 1);
        repeat (5) tick();
        redirect    = 1'b1;
        redirect_pc = 64'h3002;
        #1;
        check_eq("sim_out_valid", out_valid, 1);
        check_eq("sim_resp_valid", resp_valid, 1);
        check_eq("sim_out_pc", out_pc, 64'h1008);
        tick();
        redirect = 1'b0;
        #1;
        check_eq("sim_flushed", out_valid, 0);
        repeat (8) tick();
        check_eq("sim_pc2", cons_pc[2], 64'h1008);
        check_eq("sim_pc3", cons_pc[3], 64'h3000);
        check_eq("sim_instr3", cons_instr[3], 32'hA500_3000);
        check_eq("sim_acc4", acc_log[4], 64'h3000);

        // Asynchronous reset with three requests in flight
        do_reset(64'h1000, 3);
        repeat (4) tick();
        #2;
        resetl = 1'b0;
        #1;
        check_eq("ar_req_valid", req_valid, 0);
        check_eq("ar_req_addr", req_addr, 0);
        check_eq("ar_out_valid", out_valid, 0);
        check_eq("ar_out_instr", out_instr, 0);
        check_eq("ar_out_pc", out_pc, 0);
        do_reset(64'h4000, 3);
        tick();
        #1;
        check_eq("ar_restart_valid", req_valid, 1);
        check_eq("ar_restart_addr", req_addr, 64'h4000);
        repeat (8) tick();
        check_eq("ar_pc0", cons_pc[0], 64'h4000);
        check_eq("ar_instr0", cons_instr[0], 32'hA500_4000);

        // PC wraps at the top of the address space
        do_reset(64'hFFFF_FFFF_FFFF_FFFC, 1);
        repeat (6) tick();
        check_eq("wrap_acc1", acc_log[1], 64'h0);
        check_eq("wrap_pc0", cons_pc[0], 64'hFFFF_FFFF_FFFF_FFFC);
        check_eq("wrap_pc1", cons_pc[1], 64'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
